// File: rtl/drive_input_ctrl.sv
// drive_input_ctrl
//   Turns raw accel/decel/gear push-buttons into speed-stage control pulses and
//   maintains the gear register with an overspeed interlock on downshift.
// Ports
//   clk_i            system clock, rising edge
//   rst_i            asynchronous, active-high reset
//   btn_accel_i      raw accelerator button (async)
//   btn_decel_i      raw brake button (async)
//   btn_gear_up_i    raw upshift button (async)
//   btn_gear_down_i  raw downshift button (async)
//   speed_level_i    current level fed back from the speed-level stage
//   accel_pulse_o    one-cycle increment request
//   decel_pulse_o    one-cycle decrement request
//   gear_o           current gear, 1..6
//   shift_reject_o   one-cycle flag, shift request refused
//
// Repeat FSM (one each for accel and decel)
//   state     | meaning
//   ST_IDLE   | button released or blocked, waiting for a debounced rise
//   ST_FIRE   | emit first pulse, load repeat delay
//   ST_HOLD   | counting down the initial repeat delay
//   ST_REPEAT | counting down the repeat period, pulse at terminal count
module drive_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 5,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned MAX_L1          = 3,
  parameter int unsigned MAX_L2          = 5,
  parameter int unsigned MAX_L3          = 7,
  parameter int unsigned MAX_L4          = 9,
  parameter int unsigned MAX_L5          = 12,
  parameter int unsigned MAX_L6          = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_accel_i,
  input  logic       btn_decel_i,
  input  logic       btn_gear_up_i,
  input  logic       btn_gear_down_i,
  input  logic [3:0] speed_level_i,
  output logic       accel_pulse_o,
  output logic       decel_pulse_o,
  output logic [2:0] gear_o,
  output logic       shift_reject_o
);

  // Button index: 0 accel, 1 decel, 2 gear up, 3 gear down
  localparam int NB = 4;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Counters reload with N-1 so consecutive pulses are exactly N cycles apart
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_HOLD, ST_REPEAT} rep_state_e;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync2_q, deb_q, deb_dly_q, rise;
  logic [CNT_W-1:0] dbc_q [NB];

  assign raw  = {btn_gear_down_i, btn_gear_up_i, btn_decel_i, btn_accel_i};
  assign rise = deb_q & ~deb_dly_q;

  // Synchroniser and debounce: counter runs only while the synced value
  // disagrees with the debounced level, so any return clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < NB; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DB_LAST) begin
          deb_q[i] <= sync2_q[i];
          dbc_q[i] <= '0;
        end else begin
          dbc_q[i] <= dbc_q[i] + 1'b1;
        end
      end
    end
  end

  rep_state_e       st_q [2];
  logic [CNT_W-1:0] rc_q [2];
  logic [1:0]       pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pulse_q <= '0;
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= ST_IDLE;
        rc_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        // accel (c=0) is held off whenever decel is debounced high
        if (!deb_q[c] || (c == 0 && deb_q[1])) begin
          st_q[c]    <= ST_IDLE;
          rc_q[c]    <= '0;
          pulse_q[c] <= 1'b0;
        end else begin
          case (st_q[c])
            ST_IDLE: begin
              pulse_q[c] <= 1'b0;
              if (rise[c]) st_q[c] <= ST_FIRE;
            end
            ST_FIRE: begin
              pulse_q[c] <= 1'b1;
              rc_q[c]    <= DELAY_LD;
              st_q[c]    <= ST_HOLD;
            end
            ST_HOLD, ST_REPEAT: begin
              if (rc_q[c] == '0) begin
                pulse_q[c] <= 1'b1;
                rc_q[c]    <= PERIOD_LD;
                st_q[c]    <= ST_REPEAT;
              end else begin
                pulse_q[c] <= 1'b0;
                rc_q[c]    <= rc_q[c] - 1'b1;
              end
            end
            default: begin
              pulse_q[c] <= 1'b0;
              st_q[c]    <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign accel_pulse_o = pulse_q[0];
  assign decel_pulse_o = pulse_q[1];

  logic [2:0] gear_q;
  logic       rej_q;
  logic [3:0] down_lim;

  // Ceiling of the gear we would shift down into
  always_comb begin
    down_lim = 4'd0;
    case (gear_q)
      3'd2:    down_lim = 4'(MAX_L1);
      3'd3:    down_lim = 4'(MAX_L2);
      3'd4:    down_lim = 4'(MAX_L3);
      3'd5:    down_lim = 4'(MAX_L4);
      3'd6:    down_lim = 4'(MAX_L5);
      default: down_lim = 4'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gear_q <= 3'd1;
      rej_q  <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      if (rise[2] && rise[3]) begin
        rej_q <= 1'b1;
      end else if (rise[2]) begin
        if (gear_q < 3'd6) gear_q <= gear_q + 3'd1;
        else               rej_q  <= 1'b1;
      end else if (rise[3]) begin
        if (gear_q > 3'd1 && speed_level_i <= down_lim) gear_q <= gear_q - 3'd1;
        else                                             rej_q  <= 1'b1;
      end
    end
  end

  assign gear_o         = gear_q;
  assign shift_reject_o = rej_q;

endmodule
